inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
Show-ahead instruction FIFO between fetch (i-cache return) and decode; it is the producer side of inst_q_output_ifc, which the decoder consumes.
- Buffers fetched {pc, data} pairs.
- Presents the oldest entry to decode every cycle.
- Holds the head entry while the hazard controller stalls decode.
- Drops all contents on a branch/jump redirect flush.
- Decouples i-cache latency and decode stalls.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2.
ADDR_WIDTH, mips_core_pkg::ADDR_WIDTH, pc width.
DATA_WIDTH, 32, instruction word width.

Ports:
clk  input  1  pipeline clock; all state updates on posedge.
rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
i_valid  input  1  fetched instruction present this cycle.
i_pc  input  ADDR_WIDTH  pc of the fetched instruction.
i_data  input  DATA_WIDTH  fetched instruction word.
o_ready  output  1  queue accepts a push this cycle.
i_stall  input  1  decode stalled by the hazard controller; inhibits pop.
i_flush  input  1  redirect; discard all entries.
o_valid  output  1  inst_q_output_ifc valid; head entry present.
o_pc  output  ADDR_WIDTH  inst_q_output_ifc pc of the head entry.
o_data  output  DATA_WIDTH  inst_q_output_ifc data of the head entry.
o_count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State: storage[DEPTH] of {pc, data}; rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; count register 0..DEPTH. Storage is not reset.
- push = i_valid & o_ready & ~i_flush.
- pop = o_valid & ~i_stall & ~i_flush.
- o_ready = rst_n & (count != DEPTH). Combinational from state and rst_n. No full-bypass: a push is refused when full, even if a pop occurs in the same cycle.
- o_valid = (count != 0).
- o_pc and o_data = storage[rd_ptr] when o_valid, else all zero. Driven from registers only; no combinational path from i_* to o_valid, o_pc or o_data.
- Latency: an entry pushed at edge N appears on the outputs in cycle N+1 at the earliest. There is no input-to-output bypass when empty.
- Reset: while rst_n=0 at a posedge, rd_ptr, wr_ptr and count clear to 0. Consequences:
  - o_valid=0, o_pc=0, o_data=0, o_count=0.
  - o_ready=0 throughout reset; it is 1 in the first cycle after reset is released.
  - Reset mid-operation discards all entries, including any same-cycle push.
- Flush has priority over everything except reset:
  - At that edge rd_ptr, wr_ptr and count clear to 0.
  - The same-cycle push and pop are suppressed.
  - o_valid=0 in the next cycle.
  - A push in the cycle after the flush is accepted normally.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with both pointers advancing.
  - neither: hold.
- Full: with count=DEPTH, i_valid is ignored. The fetch side must hold the instruction until o_ready=1.
- Empty: with count=0, i_stall has no effect.
- Stall: head entry, pointers and count are held stable. A concurrent push is still accepted if not full.
- Wrap: pointers roll from DEPTH-1 to 0. FIFO order must be preserved across the wrap.
- Decode deasserting valid for unsupported opcodes is downstream behaviour; the queue pops those entries like any other.

Decomposition:
- Add to mips_core_pkg:
  - typedef inst_q_entry_t, a packed struct {pc [ADDR_WIDTH-1:0], data [DATA_WIDTH-1:0]}.
  - localparam INST_Q_DEPTH = 4, used as the default for DEPTH.
- The output side drives inst_q_output_ifc.out (valid, pc, data) in the top-level hookup. The ports above are that interface flattened.
- One sub-module is natural: inst_q_ptr_ctrl. It holds rd_ptr, wr_ptr and count, and produces full/empty. Storage and the output mux remain in inst_queue.

Test Plan:
- Reset hold: rst_n=0 for 2 cycles with i_valid=1 -> o_ready=0, o_valid=0, o_count=0; after release o_ready=1 and o_valid=0.
- Fill/drain: i_stall=1; push pc 0x100/0x104/0x108/0x10C with data A0..A3 -> o_count=4, o_ready=0, head stays pc 0x100 data A0. Then release i_stall -> outputs 0x100, 0x104, 0x108, 0x10C on consecutive cycles, then o_valid=0.
- Simultaneous push/pop at count=2 over 10 cycles -> o_count stays 2, pointers wrap, output order matches push order exactly.
- Flush with push: count=3 and i_flush=1 together with push pc 0x200 -> next cycle o_valid=0, o_count=0. Then push pc 0x300 -> appears on the next cycle with o_count=1.
- Full refusal: count=4 with i_valid=1 for pc 0x400 and pop in the same cycle -> push is refused and o_count=3. The held 0x400 is accepted on the next cycle and appears after the earlier entries.
- Empty stall: count=0, i_stall=1, push pc 0x500 -> next cycle o_valid=1, o_pc=0x500. The entry is held until i_stall=0, then popped.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared MIPS core types and sizes used by the instruction queue and its interface.
package mips_core_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int INST_Q_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } inst_q_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Instruction-queue to decode handshake: the queue drives 'out', decode consumes via 'sink'.
interface inst_q_output_ifc
  import mips_core_pkg::*;
#(
  parameter int AW = ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
) ();

  logic          valid;
  logic [AW-1:0] pc;
  logic [DW-1:0] data;

  modport out  (output valid, output pc, output data);
  modport sink (input  valid, input  pc, input  data);

endinterface

// File: rtl/inst_queue_ptr_ctrl.sv
// Read/write pointers and occupancy for the instruction queue; flush clears everything.
module inst_q_ptr_ctrl
  import mips_core_pkg::*;
#(
  parameter int DEPTH = INST_Q_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [PW-1:0] rdPtr_o,
  output logic [PW-1:0] wrPtr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + PW'(1);
      if (pop_i)  rdPtr_d = rdPtr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  assign rdPtr_o = rdPtr_q;
  assign wrPtr_o = wrPtr_q;
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_queue.sv
// Show-ahead fetch-to-decode instruction FIFO; head entry is presented from registers only.
module inst_queue
  import mips_core_pkg::*;
#(
  parameter int DEPTH      = INST_Q_DEPTH,
  parameter int ADDR_WIDTH = mips_core_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic [ADDR_WIDTH-1:0]      i_pc,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic                       o_ready,
  input  logic                       i_stall,
  input  logic                       i_flush,
  inst_q_output_ifc.out              outIf,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        storage [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop;

  // A full queue refuses pushes even when a pop frees a slot in the same cycle.
  assign o_ready = rst_n & ~full;
  assign push    = i_valid & o_ready & ~i_flush;
  assign pop     = ~empty & ~i_stall & ~i_flush;

  inst_q_ptr_ctrl #(.DEPTH(DEPTH)) u_ptrCtrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (i_flush),
    .rdPtr_o (rdPtr),
    .wrPtr_o (wrPtr),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk) begin
    if (push) storage[wrPtr] <= '{pc: i_pc, data: i_data};
  end

  assign outIf.valid = ~empty;
  assign outIf.pc    = empty ? '0 : storage[rdPtr].pc;
  assign outIf.data  = empty ? '0 : storage[rdPtr].data;
  assign o_count     = count;

endmodule

// File: tb/tb_inst_queue.sv
// Directed and randomized checks of inst_queue against a queue-based FIFO reference model.
module tb_inst_queue;
  import mips_core_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_data;
  logic        o_ready;
  logic        i_stall;
  logic        i_flush;
  logic [2:0]  o_count;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  entry_t modelQ[$];

  inst_q_output_ifc #(.AW(32), .DW(32)) outIf ();

  inst_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_pc    (i_pc),
    .i_data  (i_data),
    .o_ready (o_ready),
    .i_stall (i_stall),
    .i_flush (i_flush),
    .outIf   (outIf),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare every DUT output with what the reference queue says it should show now.
  task automatic checkModel(input string tag);
    logic        expValid;
    logic [31:0] expPc, expData;
    expValid = (modelQ.size() != 0);
    expPc    = expValid ? modelQ[0].pc   : 32'h0;
    expData  = expValid ? modelQ[0].data : 32'h0;
    checkOutput({tag, ".ready"}, 64'(o_ready),     64'(rst_n && (modelQ.size() < DEPTH)));
    checkOutput({tag, ".valid"}, 64'(outIf.valid), 64'(expValid));
    checkOutput({tag, ".pc"},    64'(outIf.pc),    64'(expPc));
    checkOutput({tag, ".data"},  64'(outIf.data),  64'(expData));
    checkOutput({tag, ".count"}, 64'(o_count),     64'(modelQ.size()));
  endtask

  // One clock cycle: drive inputs after the falling edge, advance the model, check after the rising edge.
  task automatic applyStimulus(input string tag, input logic rstn, input logic valid,
                               input logic [31:0] pc, input logic [31:0] data,
                               input logic stall, input logic flush);
    logic   ready, doPush, doPop;
    entry_t e;
    @(negedge clk);
    rst_n   = rstn;
    i_valid = valid;
    i_pc    = pc;
    i_data  = data;
    i_stall = stall;
    i_flush = flush;
    ready  = rstn && (modelQ.size() < DEPTH);
    doPush = valid && ready && !flush;
    doPop  = (modelQ.size() != 0) && !stall && !flush;
    e.pc   = pc;
    e.data = data;
    @(posedge clk);
    #1;
    if (!rstn || flush) modelQ.delete();
    else begin
      if (doPop)  void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(e);
    end
    checkModel(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_pc    = '0;
    i_data  = '0;
    i_stall = 1'b0;
    i_flush = 1'b0;

    // Reset hold with a pending fetch
    for (int i = 0; i < 2; i++) applyStimulus("reset", 1'b0, 1'b1, 32'h900, 32'h99, 1'b0, 1'b0);
    checkOutput("rst.ready", 64'(o_ready), 64'd0);
    checkOutput("rst.valid", 64'(outIf.valid), 64'd0);
    checkOutput("rst.count", 64'(o_count), 64'd0);
    applyStimulus("release", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("rel.ready", 64'(o_ready), 64'd1);
    checkOutput("rel.valid", 64'(outIf.valid), 64'd0);

    // Fill under stall, then drain in order
    for (int i = 0; i < 4; i++)
      applyStimulus("fill", 1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1, 1'b0);
    checkOutput("full.count", 64'(o_count), 64'd4);
    checkOutput("full.ready", 64'(o_ready), 64'd0);
    checkOutput("full.pc",    64'(outIf.pc), 64'h100);
    checkOutput("full.data",  64'(outIf.data), 64'hA0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("drain", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("drain.pc", 64'(outIf.pc), 64'(32'h104 + 32'(4 * i)));
    end
    applyStimulus("drain", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("drain.empty", 64'(outIf.valid), 64'd0);

    // Steady push+pop at occupancy 2 across pointer wrap
    for (int i = 0; i < 2; i++)
      applyStimulus("pp.seed", 1'b1, 1'b1, 32'h600 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("pp", 1'b1, 1'b1, 32'h608 + 32'(4 * i), 32'hB2 + 32'(i), 1'b0, 1'b0);
      checkOutput("pp.count", 64'(o_count), 64'd2);
      checkOutput("pp.order", 64'(outIf.pc), 64'(32'h604 + 32'(4 * i)));
    end

    // Flush beats a same-cycle push
    applyStimulus("fl.seed", 1'b1, 1'b1, 32'h630, 32'hC0, 1'b1, 1'b0);
    checkOutput("fl.pre", 64'(o_count), 64'd3);
    applyStimulus("flush", 1'b1, 1'b1, 32'h200, 32'hC1, 1'b0, 1'b1);
    checkOutput("flush.valid", 64'(outIf.valid), 64'd0);
    checkOutput("flush.count", 64'(o_count), 64'd0);
    applyStimulus("postfl", 1'b1, 1'b1, 32'h300, 32'hC2, 1'b1, 1'b0);
    checkOutput("postfl.pc",    64'(outIf.pc), 64'h300);
    checkOutput("postfl.count", 64'(o_count), 64'd1);

    // Full refusal with concurrent pop; held fetch lands behind older entries
    for (int i = 1; i < 4; i++)
      applyStimulus("fr.fill", 1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'hC2 + 32'(i), 1'b1, 1'b0);
    applyStimulus("fr.refuse", 1'b1, 1'b1, 32'h400, 32'hD0, 1'b0, 1'b0);
    checkOutput("fr.count", 64'(o_count), 64'd3);
    checkOutput("fr.head",  64'(outIf.pc), 64'h304);
    applyStimulus("fr.accept", 1'b1, 1'b1, 32'h400, 32'hD0, 1'b1, 1'b0);
    checkOutput("fr.count2", 64'(o_count), 64'd4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("fr.drain", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("fr.order", 64'(outIf.pc), (i == 2) ? 64'h400 : 64'(32'h308 + 32'(4 * i)));
    end
    applyStimulus("fr.drain", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Stall on empty queue does not block the push; entry held until stall drops
    applyStimulus("es.push", 1'b1, 1'b1, 32'h500, 32'hE0, 1'b1, 1'b0);
    checkOutput("es.pc", 64'(outIf.pc), 64'h500);
    applyStimulus("es.hold", 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("es.held", 64'(outIf.pc), 64'h500);
    applyStimulus("es.pop", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("es.empty", 64'(outIf.valid), 64'd0);

    // Randomized traffic with occasional stall, flush and reset
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 99) < 65),
                    $urandom, $urandom,
                    ($urandom_range(0, 99) < 35),
                    ($urandom_range(0, 99) < 4));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
